// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE      = 0;
    localparam int PAR_EVEN      = 1;
    localparam int PAR_ODD       = 2;
    localparam int MAX_DATA_BITS = 9;

    // Zero-extended data does not change the XOR, so one width serves every frame size.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     odd_sel);
        return (^data) ^ odd_sel;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud interval counter: counts 0..CLKS_PER_BIT-1, flags the terminal count, clears on demand.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count,
    output logic                            tick
);
    import uart_pkg::*;

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_r;

    // Count register; returns to zero at the terminal count so it never wraps past it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear || tick) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign tick  = (count_r == CNT_LAST);
    assign count = count_r;

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter draining a ready/valid word stream; frame = start, data LSB first,
// optional parity, stop bits. All outputs come straight from flops.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 ready_in,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam int            BW         = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY != PAR_NONE);
    localparam bit            ODD_PARITY = (PARITY == PAR_ODD);

    if ((CLKS_PER_BIT < 2) || (DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS) ||
        (PARITY < PAR_NONE) || (PARITY > PAR_ODD) ||
        (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_params
        $error("uart_tx_stream: parameter out of range");
    end

    uart_state_t          state_r;
    uart_state_t          state_s;
    logic [BW-1:0]        bit_r;
    logic [BW-1:0]        bit_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_s;
    logic                 par_r;
    logic                 par_s;
    logic                 tx_r;
    logic                 tx_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 ready_r;
    logic                 ready_s;
    logic                 clear_s;
    logic                 tick_s;
    logic [CW-1:0]        count_s;
    logic                 accept_s;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear_s),
        .count  (count_s),
        .tick   (tick_s)
    );

    assign accept_s = ready_r && valid_in;

    // Next-state logic: advance on baud ticks, latch the word (and its parity) on a handshake.
    always_comb begin
        state_s = state_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        par_s   = par_r;
        clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = START;
                    shift_s = data_in;
                    par_s   = parity_bit(MAX_DATA_BITS'(data_in), ODD_PARITY);
                    bit_s   = {BW{1'b0}};
                    clear_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_s = DATA;
                    bit_s   = {BW{1'b0}};
                    clear_s = 1'b1;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_s = shift_r >> 1;
                    clear_s = 1'b1;
                    if (bit_r == DATA_LAST) begin
                        state_s = HAS_PARITY ? uart_pkg::PARITY : STOP;
                        bit_s   = {BW{1'b0}};
                    end else begin
                        bit_s = bit_r + BW'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            uart_pkg::PARITY: begin
                if (tick_s) begin
                    state_s = STOP;
                    bit_s   = {BW{1'b0}};
                    clear_s = 1'b1;
                end else begin
                    state_s = uart_pkg::PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    clear_s = 1'b1;
                    if (bit_r == STOP_LAST) begin
                        bit_s = {BW{1'b0}};
                        // Handshake in the final stop cycle chains the next frame with no idle gap.
                        if (accept_s) begin
                            state_s = START;
                            shift_s = data_in;
                            par_s   = parity_bit(MAX_DATA_BITS'(data_in), ODD_PARITY);
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        bit_s = bit_r + BW'(1);
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                bit_s   = {BW{1'b0}};
                clear_s = 1'b1;
            end
        endcase
    end

    // Output decode from the next state so tx/busy/ready can be registered without lag.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            IDLE:             tx_s = 1'b1;
            START:            tx_s = 1'b0;
            DATA:             tx_s = shift_s[0];
            uart_pkg::PARITY: tx_s = par_s;
            STOP:             tx_s = 1'b1;
            default:          tx_s = 1'b1;
        endcase
        busy_s = (state_s != IDLE);
        // The baud count reaches its last value next cycle only if it sits one below now.
        if (state_s == IDLE) begin
            ready_s = 1'b1;
        end else if ((state_s == STOP) && (bit_s == STOP_LAST) &&
                     !clear_s && (count_s == CNT_PENULT)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // State and output registers; reset forces the line idle and abandons any frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            bit_r   <= {BW{1'b0}};
            shift_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            ready_r <= ready_s;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign ready_in = ready_r;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: three parameterisations checked cycle by cycle
// against frame waveforms built from the bit-level frame definition.
module tb_uart_tx_stream;

    localparam int CPB  = 4;
    localparam int NDUT = 3;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NDUT-1:0]       valid;
    logic [NDUT-1:0][7:0]  data;
    logic [NDUT-1:0]       ready;
    logic [NDUT-1:0]       tx;
    logic [NDUT-1:0]       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .ready_in(ready[0]), .valid_in(valid[0]),
        .data_in(data[0]), .tx(tx[0]), .busy(busy[0]));
    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ready_in(ready[1]), .valid_in(valid[1]),
        .data_in(data[1]), .tx(tx[1]), .busy(busy[1]));
    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .ready_in(ready[2]), .valid_in(valid[2]),
        .data_in(data[2]), .tx(tx[2]), .busy(busy[2]));

    function automatic int par_of(input int idx);
        return (idx == 0) ? 0 : ((idx == 1) ? 1 : 2);
    endfunction

    function automatic int stop_of(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int par, input int stops);
        return (1 + 8 + ((par != 0) ? 1 : 0) + stops) * CPB;
    endfunction

    function automatic logic [127:0] ones(input int n);
        return (128'd1 << n) - 128'd1;
    endfunction

    // Reference frame: bit k-1 is the tx level expected in cycle k after the handshake.
    function automatic logic [127:0] frame_wave(input logic [7:0] d, input int par, input int stops);
        logic [127:0] w;
        logic         b;
        int           nbits;
        w     = '0;
        nbits = frame_len(par, stops) / CPB;
        for (int j = 0; j < nbits; j++) begin
            if (j == 0)                    b = 1'b0;
            else if (j <= 8)               b = d[j-1];
            else if (par != 0 && j == 9)   b = (($countones(d) % 2) == 1) ^ (par == 2);
            else                           b = 1'b1;
            for (int c = 0; c < CPB; c++) w[j*CPB + c] = b;
        end
        return w;
    endfunction

    task automatic start_frame(input int idx, input logic [7:0] d);
        valid[idx] = 1'b1;
        data[idx]  = d;
        @(negedge clk);
    endtask

    // Records n cycles of outputs starting at cycle 1; valid drops from cycle drop_at on.
    task automatic run_frame(input int idx, input int n, input int drop_at, input bit noise,
                             output logic [127:0] txw, output logic [127:0] rdw,
                             output logic [127:0] bsw);
        txw = '0; rdw = '0; bsw = '0;
        for (int k = 1; k <= n; k++) begin
            txw[k-1] = tx[idx];
            rdw[k-1] = ready[idx];
            bsw[k-1] = busy[idx];
            if (k >= drop_at) begin
                valid[idx] = 1'b0;
            end else if (noise) begin
                valid[idx] = 1'($urandom);
                data[idx]  = 8'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic idle_bad;
        reset_n = 1'b0;
        valid   = '1;
        data    = {8'h5A, 8'hC3, 8'h81};
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 3'b111) begin errors++; $display("FAIL reset_tx: got %b expected 111", tx); end
        checks++;
        if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", ready); end
        checks++;
        if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", busy); end
        reset_n = 1'b1;
        valid   = '0;
        @(negedge clk);
        checks++;
        if (ready !== 3'b111) begin errors++; $display("FAIL release_ready: got %b expected 111", ready); end
        idle_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx !== 3'b111 || busy !== 3'b000) idle_bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (idle_bad !== 1'b0) begin errors++; $display("FAIL idle_no_frame: got activity=%b expected 0", idle_bad); end
    endtask

    task automatic test_single();
        logic [127:0] txw, rdw, bsw, etx, erd, ebs, m;
        int L;
        L   = frame_len(0, 1);
        m   = ones(L + 4);
        etx = frame_wave(8'hA5, 0, 1) | (m & ~ones(L));
        erd = (128'd1 << (L - 1)) | (m & ~ones(L));
        ebs = ones(L);
        start_frame(0, 8'hA5);
        run_frame(0, L + 4, 1, 1'b0, txw, rdw, bsw);
        checks++;
        if (((txw ^ etx) & m) !== '0) begin errors++; $display("FAIL single_tx: got %h expected %h", txw & m, etx & m); end
        checks++;
        if (((rdw ^ erd) & m) !== '0) begin errors++; $display("FAIL single_ready: got %h expected %h", rdw & m, erd & m); end
        checks++;
        if (((bsw ^ ebs) & m) !== '0) begin errors++; $display("FAIL single_busy: got %h expected %h", bsw & m, ebs & m); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] txw, rdw, bsw, etx, erd, ebs, m;
        int L;
        L   = frame_len(0, 1);
        m   = ones(2*L + 8);
        etx = frame_wave(8'h00, 0, 1) | (frame_wave(8'hFF, 0, 1) << L) | (m & ~ones(2*L));
        erd = (128'd1 << (L - 1)) | (128'd1 << (2*L - 1)) | (m & ~ones(2*L));
        ebs = ones(2*L);
        start_frame(0, 8'h00);
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        run_frame(0, 2*L + 8, L + 1, 1'b0, txw, rdw, bsw);
        checks++;
        if (((txw ^ etx) & m) !== '0) begin errors++; $display("FAIL b2b_tx: got %h expected %h", txw & m, etx & m); end
        checks++;
        if (((rdw ^ erd) & m) !== '0) begin errors++; $display("FAIL b2b_ready: got %h expected %h", rdw & m, erd & m); end
        checks++;
        if (((bsw ^ ebs) & m) !== '0) begin errors++; $display("FAIL b2b_busy: got %h expected %h", bsw & m, ebs & m); end
    endtask

    task automatic test_parity();
        logic [127:0] txw, rdw, bsw, etx, erd, ebs, m;
        int L;
        for (int idx = 1; idx <= 2; idx++) begin
            L   = frame_len(par_of(idx), stop_of(idx));
            m   = ones(L + 4);
            etx = frame_wave(8'h07, par_of(idx), stop_of(idx)) | (m & ~ones(L));
            erd = (128'd1 << (L - 1)) | (m & ~ones(L));
            ebs = ones(L);
            start_frame(idx, 8'h07);
            run_frame(idx, L + 4, 1, 1'b0, txw, rdw, bsw);
            checks++;
            if (txw[37] !== ((idx == 1) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL parity_bit%0d: got %b expected %b", idx, txw[37], (idx == 1));
            end
            checks++;
            if (((txw ^ etx) & m) !== '0) begin errors++; $display("FAIL parity_tx%0d: got %h expected %h", idx, txw & m, etx & m); end
            checks++;
            if (((rdw ^ erd) & m) !== '0) begin errors++; $display("FAIL parity_ready%0d: got %h expected %h", idx, rdw & m, erd & m); end
            checks++;
            if (((bsw ^ ebs) & m) !== '0) begin errors++; $display("FAIL parity_busy%0d: got %h expected %h", idx, bsw & m, ebs & m); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] txw, rdw, bsw, etx, erd, ebs, m;
        int L;
        start_frame(0, 8'h00);
        run_frame(0, 17, 1, 1'b0, txw, rdw, bsw);
        checks++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got tx=%b busy=%b expected tx=0 busy=1", tx[0], busy[0]);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
            errors++; $display("FAIL midreset_async: got tx=%b busy=%b ready=%b expected 1 0 0", tx[0], busy[0], ready[0]);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        L   = frame_len(0, 1);
        m   = ones(L + 4);
        etx = frame_wave(8'h3C, 0, 1) | (m & ~ones(L));
        erd = (128'd1 << (L - 1)) | (m & ~ones(L));
        ebs = ones(L);
        start_frame(0, 8'h3C);
        run_frame(0, L + 4, 1, 1'b0, txw, rdw, bsw);
        checks++;
        if (((txw ^ etx) & m) !== '0) begin errors++; $display("FAIL postreset_tx: got %h expected %h", txw & m, etx & m); end
        checks++;
        if (((bsw ^ ebs) & m) !== '0 || ((rdw ^ erd) & m) !== '0) begin
            errors++; $display("FAIL postreset_hs: got busy=%h ready=%h expected busy=%h ready=%h", bsw & m, rdw & m, ebs & m, erd & m);
        end
    endtask

    task automatic test_input_noise();
        logic [127:0] txw, rdw, bsw, etx, erd, ebs, m;
        logic [7:0]   b;
        int L;
        for (int r = 0; r < 2; r++) begin
            b   = 8'($urandom);
            L   = frame_len(0, 1);
            m   = ones(L + 8);
            etx = frame_wave(b, 0, 1) | (m & ~ones(L));
            erd = (128'd1 << (L - 1)) | (m & ~ones(L));
            ebs = ones(L);
            start_frame(0, b);
            run_frame(0, L + 8, L, 1'b1, txw, rdw, bsw);
            checks++;
            if (((txw ^ etx) & m) !== '0) begin errors++; $display("FAIL noise_tx: got %h expected %h byte %h", txw & m, etx & m, b); end
            checks++;
            if (((bsw ^ ebs) & m) !== '0 || ((rdw ^ erd) & m) !== '0) begin
                errors++; $display("FAIL noise_hs: got busy=%h ready=%h expected busy=%h ready=%h", bsw & m, rdw & m, ebs & m, erd & m);
            end
        end
    endtask

    task automatic test_random_frames();
        logic [127:0] txw, rdw, bsw, etx, erd, ebs, m;
        logic [7:0]   b;
        int idx, L;
        for (int r = 0; r < 6; r++) begin
            idx = $urandom_range(0, NDUT - 1);
            b   = 8'($urandom);
            L   = frame_len(par_of(idx), stop_of(idx));
            m   = ones(L + 4);
            etx = frame_wave(b, par_of(idx), stop_of(idx)) | (m & ~ones(L));
            erd = (128'd1 << (L - 1)) | (m & ~ones(L));
            ebs = ones(L);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_frame(idx, b);
            run_frame(idx, L + 4, 1, 1'b0, txw, rdw, bsw);
            checks++;
            if (((txw ^ etx) & m) !== '0 || ((bsw ^ ebs) & m) !== '0 || ((rdw ^ erd) & m) !== '0) begin
                errors++; $display("FAIL random_dut%0d_%h: got tx=%h busy=%h ready=%h expected tx=%h", idx, b, txw & m, bsw & m, rdw & m, etx & m);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = '0;
        data    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_input_noise();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
